store_unit: RTL and testbench

- Write-side counterpart of the load path in the green datapath.
- Decodes store opcodes, computes the RAM address, and buffers (address, data) pairs in a small queue.
- Drains the queue into the shared single-port RAM, one write per granted cycle.
- Also performs block-fill stores: N consecutive words of the same value, sequenced by an internal FSM.

---
 rtl/store_unit_pkg.sv | 23 ++
 rtl/store_fifo.sv | 44 ++++
 rtl/store_unit.sv | 131 +++++++++++++
 tb/tb_store_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_unit_pkg.sv
// Shared definitions for the green datapath load/store units:
// opcode values, opcode field positions and the store FSM encoding.
package store_unit_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_STB = 4'h3;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int LEN_MSB = 11;
  localparam int LEN_LSB = 8;
  localparam int OFS_MSB = 7;
  localparam int OFS_LSB = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

endpackage

// File: rtl/store_fifo.sv
// Store queue: synchronous FIFO of (address, data) entries with
// extra-bit wrap pointers so full and empty are distinguishable.
module store_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: decodes single and block-fill stores, queues (addr, data)
// pairs and drains them into the shared RAM port whenever it is granted.
module store_unit #(
  parameter int         DEPTH  = 4,
  parameter int         ADDR_W = store_unit_pkg::ADDR_W_DEF,
  parameter int         DATA_W = store_unit_pkg::DATA_W_DEF,
  parameter logic [3:0] OP_ST  = store_unit_pkg::OP_ST,
  parameter logic [3:0] OP_STB = store_unit_pkg::OP_STB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] opCode,
  input  logic [DATA_W-1:0] A_in,
  input  logic [DATA_W-1:0] B_in,
  input  logic              ram_grant,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_in,
  output logic              busy,
  output logic              err
);

  import store_unit_pkg::*;

  localparam int EW = ADDR_W + DATA_W;
  localparam int CW = $clog2(DEPTH) + 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
  logic [DATA_W-1:0] fill_data, fill_data_nxt;
  logic [3:0]        remaining, remaining_nxt;
  logic              err_nxt;

  logic              push, pop, full, empty;
  logic [EW-1:0]     push_entry, head;
  logic [CW-1:0]     count;
  logic [3:0]        op;
  logic [ADDR_W-1:0] op_addr;
  logic              accept;
  logic              unused_b_hi;

  // Handshake: an opcode is taken on an edge where op_valid && op_ready.
  assign op       = opCode[OP_MSB:OP_LSB];
  assign op_addr  = B_in[ADDR_W-1:0] + ADDR_W'(opCode[OFS_MSB:OFS_LSB]);
  assign op_ready = en && (state == S_IDLE) && !full;
  assign accept   = op_valid && op_ready;
  assign pop      = ram_grant && !empty;
  assign busy     = (state != S_IDLE) || (count != '0);
  assign unused_b_hi = ^B_in[DATA_W-1:ADDR_W];

  always_comb begin
    state_nxt     = state;
    cur_addr_nxt  = cur_addr;
    fill_data_nxt = fill_data;
    remaining_nxt = remaining;
    push          = 1'b0;
    push_entry    = {op_addr, A_in};
    err_nxt       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_ST) begin
            push = 1'b1;
          end else if (op == OP_STB) begin
            push          = 1'b1;
            cur_addr_nxt  = op_addr + ADDR_W'(1);
            fill_data_nxt = A_in;
            remaining_nxt = opCode[LEN_MSB:LEN_LSB];
            if (opCode[LEN_MSB:LEN_LSB] != 4'd0) state_nxt = S_FILL;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_FILL: begin
        // The first word went in on accept; remaining counts the rest.
        push_entry = {cur_addr, fill_data};
        if (!full) begin
          push          = 1'b1;
          cur_addr_nxt  = cur_addr + ADDR_W'(1);
          remaining_nxt = remaining - 4'd1;
          if (remaining == 4'd1) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      fill_data <= '0;
      remaining <= '0;
      err       <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_in    <= '0;
    end else begin
      state     <= state_nxt;
      cur_addr  <= cur_addr_nxt;
      fill_data <= fill_data_nxt;
      remaining <= remaining_nxt;
      err       <= err_nxt;
      ram_we    <= pop;
      if (pop) begin
        ram_addr <= head[EW-1:DATA_W];
        ram_in   <= head[DATA_W-1:0];
      end
    end
  end

  store_fifo #(
    .DEPTH(DEPTH),
    .W    (EW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (push_entry),
    .dout (head),
    .full (full),
    .empty(empty),
    .count(count)
  );

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: directed scenarios plus random traffic, with every
// RAM write compared against a queue of expected (addr, data) words.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] opCode;
  logic [15:0] A_in;
  logic [15:0] B_in;
  logic        ram_grant;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_in;
  logic        busy;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  bit          rand_grant = 1'b0;
  logic [23:0] exp_q[$];

  store_unit dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .opCode   (opCode),
    .A_in     (A_in),
    .B_in     (B_in),
    .ram_grant(ram_grant),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_in   (ram_in),
    .busy     (busy),
    .err      (err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every RAM write must match the oldest expected word
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, ram_addr}, {24'd0, e[23:16]});
        check("wr_data", {16'd0, ram_in}, {16'd0, e[15:0]});
      end
      wr_cnt++;
    end
  end

  // reference model: the words an accepted opcode must eventually write
  task automatic model_push(input logic [15:0] opc, input logic [15:0] a, input logic [15:0] b,
                            output bit bad);
    logic [7:0] ad;
    int         n;
    ad  = b[7:0] + opc[7:0];
    bad = 1'b0;
    if (opc[15:12] == 4'h2) begin
      exp_q.push_back({ad, a});
    end else if (opc[15:12] == 4'h3) begin
      n = int'(opc[11:8]) + 1;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({ad, a});
        ad = ad + 8'd1;
      end
    end else begin
      bad = 1'b1;
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
    if (rand_grant) ram_grant = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [15:0] opc, input logic [15:0] a, input logic [15:0] b);
    int n;
    bit bad;
    n = 0;
    op_valid = 1'b1;
    opCode   = opc;
    A_in     = a;
    B_in     = b;
    #1;
    while (!op_ready && n < 300) begin
      tick();
      #1;
      n++;
    end
    check("accept_timeout", {31'd0, (n >= 300)}, 32'd0);
    if (n >= 300) begin
      op_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_push(opc, a, b, bad);
    tick();
    op_valid = 1'b0;
    check("err_pulse", {31'd0, err}, {31'd0, bad});
    if (bad) begin
      tick();
      check("err_one_cycle", {31'd0, err}, 32'd0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    rand_grant = 1'b0;
    ram_grant  = 1'b1;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    check("drain_timeout", {31'd0, busy}, 32'd0);
    tick();
    tick();
    #1;
    check("exp_q_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         w0;
    logic [5:0] pat;
    rst = 1'b0; en = 1'b1; op_valid = 1'b0; ram_grant = 1'b0;
    opCode = '0; A_in = '0; B_in = '0;
    #1 rst = 1'b1;
    #11;
    check("rst_ram_we",   {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    check("rst_ram_in",   {16'd0, ram_in}, 32'd0);
    check("rst_err",      {31'd0, err}, 32'd0);
    check("rst_busy",     {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single store, two-edge latency
    ram_grant = 1'b1;
    issue(16'h2005, 16'hBEEF, 16'h0010);
    check("st_we_early", {31'd0, ram_we}, 32'd0);
    tick();
    check("st_we",   {31'd0, ram_we}, 32'd1);
    check("st_addr", {24'd0, ram_addr}, 32'h15);
    check("st_data", {16'd0, ram_in}, 32'hBEEF);
    tick();
    check("st_we_off", {31'd0, ram_we}, 32'd0);
    check("st_busy",   {31'd0, busy}, 32'd0);

    // block fill across the address wrap
    #1 w0 = wr_cnt;
    issue(16'h3302, 16'h1234, 16'h00FE);
    check("fill_ready_low", {31'd0, op_ready}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      pat[i] = ram_we;
    end
    #1;
    check("fill_b2b", {26'd0, pat}, 32'h0F);
    check("fill_count", wr_cnt - w0, 32'd4);
    check("fill_exp_empty", exp_q.size(), 32'd0);

    // backpressure with the grant withheld
    #1 w0 = wr_cnt;
    ram_grant = 1'b0;
    for (int i = 0; i < 4; i++) issue(16'h2000 | 16'(i), 16'hA000 + 16'(i), 16'h0040);
    op_valid = 1'b1;
    opCode   = 16'h2004;
    #1;
    check("bp_ready_low", {31'd0, op_ready}, 32'd0);
    check("bp_busy", {31'd0, busy}, 32'd1);
    ram_grant = 1'b1;
    issue(16'h2004, 16'hA004, 16'h0040);
    drain();
    check("bp_count", wr_cnt - w0, 32'd5);

    // unsupported opcode
    w0 = wr_cnt;
    issue(16'h7000, 16'hDEAD, 16'h0001);
    check("bad_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    #1;
    check("bad_no_write", wr_cnt - w0, 32'd0);

    // en dropped during a 16-word fill, then en=0 in IDLE
    w0 = wr_cnt;
    issue(16'h3F00, 16'h5A5A, 16'h0080);
    en = 1'b0;
    drain();
    check("fill16_count", wr_cnt - w0, 32'd16);
    w0 = wr_cnt;
    op_valid = 1'b1;
    opCode   = 16'h2001;
    #1;
    check("en_ready_low", {31'd0, op_ready}, 32'd0);
    repeat (5) tick();
    #1;
    check("en_no_write", wr_cnt - w0, 32'd0);
    check("en_busy", {31'd0, busy}, 32'd0);
    op_valid = 1'b0;
    en = 1'b1;

    // asynchronous reset during a fill with three queued entries
    ram_grant = 1'b0;
    issue(16'h3F00, 16'hC3C3, 16'h0000);
    tick();
    tick();
    ram_grant = 1'b1;
    @(posedge clk);
    #3;
    check("mid_we_before", {31'd0, ram_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_we_fall", {31'd0, ram_we}, 32'd0);
    check("mid_busy",    {31'd0, busy}, 32'd0);
    check("mid_ready",   {31'd0, op_ready}, 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1 w0 = wr_cnt;
    repeat (20) tick();
    #1;
    check("mid_no_write", wr_cnt - w0, 32'd0);
    check("mid_idle", {31'd0, busy}, 32'd0);

    // random traffic with a randomly toggling grant
    rand_grant = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int          r;
      logic [3:0]  o;
      logic [3:0]  len;
      r   = $urandom_range(0, 9);
      len = 4'($urandom_range(0, 5));
      if (r < 6) o = 4'h2;
      else if (r < 9) o = 4'h3;
      else begin
        o = 4'($urandom_range(0, 13));
        if (o >= 4'h2) o = o + 4'h2;
      end
      issue({o, len, 8'($urandom_range(0, 255))}, 16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
